// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types and sizes for the guess issuer
package guess_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        SUBMIT,
        WAIT_GRADE,
        DONE
    } issuer_state_t;

    localparam int NUM_COINS = 4;
    localparam int SHAPE_W   = 3;
    localparam int GUESS_W   = 12;

endpackage

// File: rtl/coin_packer.sv
// rtl/coin_packer.sv - packs shape codes into the Guess word and counts coins
module coin_packer
    import guess_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_rewind,
    input  logic               i_restart,
    input  logic [SHAPE_W-1:0] i_value,
    output logic [GUESS_W-1:0] o_guess,
    output logic [2:0]         o_count
);

    logic [GUESS_W-1:0] r_guess;
    logic [2:0]         r_count;

    // Rewind drops the count but keeps the graded guess visible; the first
    // coin after it wipes the stale slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guess <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_guess <= '0;
            r_count <= '0;
        end else if (i_rewind) begin
            r_count <= '0;
        end else if (i_load && (r_count < 3'(NUM_COINS))) begin
            if (i_restart)
                r_guess <= {{(GUESS_W-SHAPE_W){1'b0}}, i_value};
            else
                r_guess[r_count[1:0]*SHAPE_W +: SHAPE_W] <= i_value;
            r_count <= r_count + 3'd1;
        end
    end

    assign o_guess = r_guess;
    assign o_count = r_count;

endmodule

// File: rtl/guess_issuer.sv
// rtl/guess_issuer.sv - player-side coin entry, grade request and completion tracking
module guess_issuer
    import guess_pkg::*;
#(
    parameter int NUM_SHAPES     = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               CLOCK_50,
    input  logic               reset_L,
    input  logic [2:0]         CoinValue,
    input  logic               CoinValid,
    input  logic               Clear,
    input  logic               Submit,
    input  logic               ready,
    input  logic [3:0]         RoundNumber,
    input  logic               GameOver,
    input  logic               GameWon,
    output logic [GUESS_W-1:0] Guess,
    output logic               GradeIt,
    output logic [2:0]         CoinCount,
    output logic               Busy,
    output logic               BadCoin,
    output logic               GradeTimeout,
    output logic               Won
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    issuer_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_rn_q;
    logic             r_grade_it;
    logic             r_busy;
    logic             r_bad;
    logic             r_timeout;
    logic             r_won;
    logic             r_fresh;

    logic w_entry_live;
    logic w_full;
    logic w_coin_ok;
    logic w_accept;
    logic w_clear;
    logic w_load;
    logic w_bad;
    logic w_rn_change;
    logic w_rewind;

    assign w_entry_live = (r_state == ENTRY) && !GameOver;
    assign w_full       = (CoinCount == 3'(NUM_COINS));
    assign w_coin_ok    = (32'(CoinValue) < NUM_SHAPES);
    assign w_accept     = w_entry_live && !Clear && Submit && w_full && ready;
    assign w_clear      = w_entry_live && Clear;
    assign w_load       = w_entry_live && !Clear && !w_accept && CoinValid && w_coin_ok;
    assign w_bad        = w_entry_live && !Clear && !w_accept && CoinValid && !w_coin_ok;
    assign w_rn_change  = (RoundNumber != r_rn_q);
    assign w_rewind     = (r_state == WAIT_GRADE) && w_rn_change && !GameOver;

    coin_packer u_packer (
        .clk       (CLOCK_50),
        .rst_n     (reset_L),
        .i_load    (w_load),
        .i_clear   (w_clear),
        .i_rewind  (w_rewind),
        .i_restart (r_fresh),
        .i_value   (CoinValue),
        .o_guess   (Guess),
        .o_count   (CoinCount)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= ENTRY;
            r_cnt      <= '0;
            r_rn_q     <= '0;
            r_grade_it <= 1'b0;
            r_busy     <= 1'b0;
            r_bad      <= 1'b0;
            r_timeout  <= 1'b0;
            r_won      <= 1'b0;
            r_fresh    <= 1'b0;
        end else begin
            r_grade_it <= 1'b0;
            r_timeout  <= 1'b0;
            r_bad      <= w_bad;
            case (r_state)
                ENTRY: begin
                    if (GameOver) begin
                        r_state <= DONE;
                        r_won   <= GameWon;
                        r_busy  <= 1'b1;
                    end else if (w_accept) begin
                        r_state    <= SUBMIT;
                        r_rn_q     <= RoundNumber;
                        r_grade_it <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                    if (w_load || w_clear)
                        r_fresh <= 1'b0;
                end
                SUBMIT: begin
                    r_state <= WAIT_GRADE;
                    r_cnt   <= '0;
                end
                WAIT_GRADE: begin
                    // A round change beats a coincident timeout.
                    if (w_rn_change) begin
                        if (GameOver) begin
                            r_state <= DONE;
                            r_won   <= GameWon;
                        end else begin
                            r_state <= ENTRY;
                            r_busy  <= 1'b0;
                            r_fresh <= 1'b1;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
                        r_state   <= ENTRY;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= ENTRY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign GradeIt      = r_grade_it;
    assign Busy         = r_busy;
    assign BadCoin      = r_bad;
    assign GradeTimeout = r_timeout;
    assign Won          = r_won;

endmodule
